// File: rtl/inst_constraint_gen_if.sv
// Harness-side instruction channel of the SQED constraint generator.
// The harness (master) drives the candidate instruction, its valid flag and
// the core's SIF commit level. The generator (slave) returns the
// combinational legality flag that the harness assumes.
interface inst_constraint_gen_if;

    logic [31:0] instruction;
    logic        inst_valid;
    logic        sif_commit;
    logic        allowed;

    modport master (
        output instruction,
        output inst_valid,
        output sif_commit,
        input  allowed
    );

    modport slave (
        input  instruction,
        input  inst_valid,
        input  sif_commit,
        output allowed
    );

endinterface : inst_constraint_gen_if

// File: rtl/inst_constraint_gen.sv
// Stateful instruction-constraint generator for the SQED formal harness.
//
// Each cycle the generator decodes the free symbolic instruction and drives
// the combinational 'allowed' flag. It also tracks three pieces of history:
//   - the commit phase (IDLE -> PRE -> LOCKED, and POST once SIF commits),
//   - the number of non-NOP instructions accepted before commit,
//   - the spacing between accepted stores.
// SIF commit arrives on a port, so the block carries no hierarchical
// references into any particular core.
//
// Optional build macro: INST_CONSTRAINT_MUL_EN
//   When defined, MUL/MULH/MULHSU/MULHU join the base legal set and count
//   toward pre_count like any other non-NOP. When undefined, those
//   encodings are illegal in every phase.
module inst_constraint_gen #(
    parameter int unsigned REG_LIMIT     = 16,
    parameter int unsigned LW_IMM_LIMIT  = 64,
    parameter int unsigned SW_IMM7_LIMIT = 2,
    parameter int unsigned MAX_PRE_INSTS = 8,
    parameter int unsigned SW_GAP        = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    inst_constraint_gen_if.slave                  cif,
    output logic [1:0]                            phase,
    output logic [$clog2(MAX_PRE_INSTS+1)-1:0]    pre_count,
    output logic                                  violation
);

    localparam int unsigned CNT_W = $clog2(MAX_PRE_INSTS + 1);
    localparam int unsigned GAP_W = (SW_GAP > 0) ? $clog2(SW_GAP + 1) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PRE_INSTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SW_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    // RV32 major opcodes used by the constraint set
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_NOP   = 7'b1111111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_PRE    = 2'd1,
        PH_LOCKED = 2'd2,
        PH_POST   = 2'd3
    } phase_e;

    phase_e             phase_q;
    logic [CNT_W-1:0]   pre_count_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               violation_q;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic [1:0]  top2;

    assign opcode = cif.instruction[6:0];
    assign rd     = cif.instruction[11:7];
    assign funct3 = cif.instruction[14:12];
    assign rs1    = cif.instruction[19:15];
    assign rs2    = cif.instruction[24:20];
    assign funct7 = cif.instruction[31:25];
    assign imm12  = cif.instruction[31:20];
    assign top2   = cif.instruction[31:30];

    // Decoded instruction classes
    logic rd_ok_c;
    logic rs1_ok_c;
    logic rs2_ok_c;
    logic is_i_c;
    logic is_r_c;
    logic is_lw_c;
    logic is_sw_c;
    logic is_jal_c;
    logic is_nop_c;
    logic is_mul_c;
    logic is_base_c;
    logic allowed_c;
    logic accepted_c;

    // Register indices must stay in the original-register half of the file
    always_comb begin
        rd_ok_c  = (32'(rd)  < REG_LIMIT);
        rs1_ok_c = (32'(rs1) < REG_LIMIT);
        rs2_ok_c = (32'(rs2) < REG_LIMIT);
    end

    // I-type ALU: ADDI/SLTI/SLTIU/XORI/ORI/ANDI plus the three shift-immediates
    always_comb begin
        is_i_c = 1'b0;
        if (opcode == OP_IMM && rd_ok_c && rs1_ok_c) begin
            unique case (funct3)
                3'b000, 3'b010, 3'b011,
                3'b100, 3'b110, 3'b111: is_i_c = 1'b1;
                3'b001:                 is_i_c = (funct7 == F7_BASE);
                3'b101:                 is_i_c = (funct7 == F7_BASE) ||
                                                 (funct7 == F7_ALT);
                default:                is_i_c = 1'b0;
            endcase
        end
    end

    // R-type base set: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND
    always_comb begin
        is_r_c = 1'b0;
        if (opcode == OP_REG && rd_ok_c && rs1_ok_c && rs2_ok_c) begin
            if (funct7 == F7_BASE) begin
                is_r_c = 1'b1;
            end else if (funct7 == F7_ALT) begin
                is_r_c = (funct3 == 3'b000) || (funct3 == 3'b101);
            end
        end
    end

    // M-extension multiplies, only legal when the optional feature is built in
    always_comb begin
        is_mul_c = 1'b0;
`ifdef INST_CONSTRAINT_MUL_EN
        if (opcode == OP_REG && funct7 == F7_MULD &&
            rd_ok_c && rs1_ok_c && rs2_ok_c) begin
            is_mul_c = (funct3[2] == 1'b0);
        end
`else
        if (opcode == OP_REG && funct7 == F7_MULD) begin
            is_mul_c = 1'b0;
        end
`endif
    end

    // Memory ops are confined to a small window addressed off x0
    always_comb begin
        is_lw_c = (opcode == OP_LOAD) && (funct3 == F3_WORD) &&
                  (top2 == 2'b00) && (rs1 == 5'd0) && rd_ok_c &&
                  (32'(imm12) < LW_IMM_LIMIT);
        is_sw_c = (opcode == OP_STORE) && (funct3 == F3_WORD) &&
                  (top2 == 2'b00) && (rs1 == 5'd0) && rs2_ok_c &&
                  (32'(funct7) < SW_IMM7_LIMIT);
    end

    // Control transfer and the harness NOP
    always_comb begin
        is_jal_c = (opcode == OP_JAL) && rd_ok_c;
        is_nop_c = (opcode == OP_NOP);
    end

    // Legality against the current (pre-edge) phase and store spacing
    always_comb begin
        is_base_c = is_i_c | is_r_c | is_lw_c | is_jal_c | is_nop_c | is_mul_c;
        allowed_c = 1'b0;
        unique case (phase_q)
            PH_IDLE, PH_PRE: allowed_c = is_base_c;
            PH_LOCKED:       allowed_c = is_nop_c;
            PH_POST:         allowed_c = is_base_c |
                                         (is_sw_c && (gap_cnt_q == '0));
            default:         allowed_c = 1'b0;
        endcase
        accepted_c = cif.inst_valid & allowed_c;
    end

    assign cif.allowed = allowed_c;

    // Phase, pre-commit budget, store gap and sticky violation tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= PH_IDLE;
            pre_count_q <= '0;
            gap_cnt_q   <= '0;
            violation_q <= 1'b0;
        end else begin
            if (cif.inst_valid && !allowed_c) begin
                violation_q <= 1'b1;
            end

            if (accepted_c) begin
                if (is_sw_c) begin
                    gap_cnt_q <= GAP_LOAD;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_q <= gap_cnt_q - GAP_ONE;
                end
            end

            if (cif.sif_commit) begin
                // Commit wins over counting; the same-cycle instruction is not counted
                phase_q <= PH_POST;
            end else begin
                unique case (phase_q)
                    PH_IDLE: begin
                        if (accepted_c && !is_nop_c) begin
                            pre_count_q <= CNT_ONE;
                            phase_q     <= (MAX_CNT == CNT_ONE) ? PH_LOCKED : PH_PRE;
                        end
                    end
                    PH_PRE: begin
                        if (accepted_c && !is_nop_c && pre_count_q != MAX_CNT) begin
                            pre_count_q <= pre_count_q + CNT_ONE;
                            if (pre_count_q + CNT_ONE == MAX_CNT) begin
                                phase_q <= PH_LOCKED;
                            end
                        end
                    end
                    PH_LOCKED: phase_q <= PH_LOCKED;
                    PH_POST:   phase_q <= PH_POST;
                    default:   phase_q <= PH_IDLE;
                endcase
            end
        end
    end

    assign phase     = phase_q;
    assign pre_count = pre_count_q;
    assign violation = violation_q;

endmodule : inst_constraint_gen

// File: tb/tb_inst_constraint_gen.sv
// Directed bench for inst_constraint_gen with default parameters
// (REG_LIMIT=16, LW_IMM_LIMIT=64, SW_IMM7_LIMIT=2, MAX_PRE_INSTS=8, SW_GAP=1).
module tb_inst_constraint_gen;

    localparam logic [31:0] ADDI    = 32'h0051_0093; // addi x1,x2,5
    localparam logic [31:0] ADD     = 32'h0031_00B3; // add  x1,x2,x3
    localparam logic [31:0] ADD_X16 = 32'h0031_0833; // add  x16,x2,x3
    localparam logic [31:0] NOP     = 32'h0000_007F;
    localparam logic [31:0] SW      = 32'h0010_2023; // sw   x1,0(x0)
    localparam logic [31:0] LW_64   = 32'h0400_2083; // lw   x1,64(x0)
    localparam logic [31:0] LW_63   = 32'h03F0_2083; // lw   x1,63(x0)
    localparam logic [31:0] MUL     = 32'h0231_00B3; // mul  x1,x2,x3

`ifdef INST_CONSTRAINT_MUL_EN
    localparam logic MUL_EXP = 1'b1;
`else
    localparam logic MUL_EXP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] phase;
    logic [3:0] pre_count;
    logic       violation;

    int tests;
    int fails;

    inst_constraint_gen_if cif ();

    inst_constraint_gen dut (
        .clk       (clk),
        .reset     (reset),
        .cif       (cif),
        .phase     (phase),
        .pre_count (pre_count),
        .violation (violation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs shortly after a rising edge and let combinational logic settle
    task automatic drive(input logic [31:0] ins, input logic v, input logic c);
        cif.instruction = ins;
        cif.inst_valid  = v;
        cif.sif_commit  = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive(NOP, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_pre_count", 32'(pre_count), 32'd0);
        check("rst_violation", 32'(violation), 32'd0);
        reset = 1'b0;

        // IDLE: legality of boundary encodings
        drive(ADD_X16, 1'b0, 1'b0);
        check("idle_add_x16", 32'(cif.allowed), 32'd0);
        drive(SW, 1'b0, 1'b0);
        check("idle_sw", 32'(cif.allowed), 32'd0);
        drive(MUL, 1'b0, 1'b0);
        check("idle_mul", 32'(cif.allowed), 32'(MUL_EXP));

        // IDLE -> PRE on the first accepted non-NOP
        drive(ADDI, 1'b1, 1'b0);
        check("idle_addi_allowed", 32'(cif.allowed), 32'd1);
        tick();
        check("pre_phase", 32'(phase), 32'd1);
        check("pre_count_1", 32'(pre_count), 32'd1);

        // NOP and idle cycles hold the budget
        drive(NOP, 1'b1, 1'b0);
        check("pre_nop_allowed", 32'(cif.allowed), 32'd1);
        tick();
        drive(ADD, 1'b0, 1'b0);
        tick();
        check("pre_hold_count", 32'(pre_count), 32'd1);
        check("pre_hold_phase", 32'(phase), 32'd1);

        // Fresh start: eight ADDs exhaust the budget
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(ADD, 1'b1, 1'b0);
            check("add_allowed", 32'(cif.allowed), 32'd1);
            tick();
            check("add_pre_count", 32'(pre_count), 32'(i + 1));
            check("add_phase", 32'(phase), (i == 7) ? 32'd2 : 32'd1);
        end
        check("locked_no_violation", 32'(violation), 32'd0);

        // LOCKED: only NOP legal
        drive(ADD, 1'b1, 1'b0);
        check("locked_add", 32'(cif.allowed), 32'd0);
        tick();
        check("locked_violation", 32'(violation), 32'd1);
        check("locked_phase", 32'(phase), 32'd2);
        check("locked_count", 32'(pre_count), 32'd8);
        drive(NOP, 1'b1, 1'b0);
        check("locked_nop", 32'(cif.allowed), 32'd1);
        drive(SW, 1'b1, 1'b0);
        check("locked_sw", 32'(cif.allowed), 32'd0);
        tick();

        // Commit with a simultaneous instruction: judged against LOCKED, not counted
        drive(ADD, 1'b1, 1'b1);
        check("commit_add_prephase", 32'(cif.allowed), 32'd0);
        tick();
        check("post_phase", 32'(phase), 32'd3);
        check("post_count", 32'(pre_count), 32'd8);
        drive(NOP, 1'b0, 1'b0);
        tick();
        check("post_hold", 32'(phase), 32'd3);

        // POST: store spacing
        drive(SW, 1'b1, 1'b0);
        check("post_sw_first", 32'(cif.allowed), 32'd1);
        tick();
        drive(SW, 1'b0, 1'b0);
        check("post_sw_gap", 32'(cif.allowed), 32'd0);
        tick();
        check("post_sw_gap_idle", 32'(cif.allowed), 32'd0);
        drive(ADDI, 1'b1, 1'b0);
        check("post_addi", 32'(cif.allowed), 32'd1);
        tick();
        check("post_count_frozen", 32'(pre_count), 32'd8);
        drive(SW, 1'b0, 1'b0);
        check("post_sw_after_gap", 32'(cif.allowed), 32'd1);

        // POST: register and immediate limits, optional multiply
        drive(ADD_X16, 1'b0, 1'b0);
        check("post_add_x16", 32'(cif.allowed), 32'd0);
        drive(LW_64, 1'b0, 1'b0);
        check("post_lw_imm64", 32'(cif.allowed), 32'd0);
        drive(LW_63, 1'b0, 1'b0);
        check("post_lw_imm63", 32'(cif.allowed), 32'd1);
        drive(MUL, 1'b0, 1'b0);
        check("post_mul", 32'(cif.allowed), 32'(MUL_EXP));

        // Reset from POST
        reset = 1'b1;
        drive(NOP, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        check("rst2_phase", 32'(phase), 32'd0);
        check("rst2_pre_count", 32'(pre_count), 32'd0);
        check("rst2_violation", 32'(violation), 32'd0);
        drive(SW, 1'b0, 1'b0);
        check("rst2_sw", 32'(cif.allowed), 32'd0);

        // Commit straight from IDLE leaves the budget at zero
        drive(NOP, 1'b0, 1'b1);
        tick();
        drive(NOP, 1'b0, 1'b0);
        check("idle_commit_phase", 32'(phase), 32'd3);
        check("idle_commit_count", 32'(pre_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_inst_constraint_gen
